fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 62 ++++++
 tb/tb_fetch_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, IF/ID latch, load-use hazard detection and redirect handling
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Instruction_address,
  input  logic [31:0] Instruction,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_RegisterRd,
  output logic [63:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic        stall,
  output logic        id_ex_bubble,
  output logic        flush_id_ex,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  logic [63:0] pc;
  logic        hazard;

  assign Instruction_address = pc;

  // A bubble in IF/ID never hazards, regardless of its decoded register fields.
  assign hazard = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) && IF_ID_valid &&
                  ((ID_EX_RegisterRd == IF_ID_instr[19:15]) ||
                   (ID_EX_RegisterRd == IF_ID_instr[24:20]));

  assign stall        = hazard && !branch_taken;
  assign id_ex_bubble = stall;
  assign flush_id_ex  = branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      IF_ID_pc    <= 64'd0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else if (branch_taken) begin
      pc          <= branch_target;
      IF_ID_pc    <= pc;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_valid <= 1'b0;
      if (flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
    end else if (stall) begin
      if (stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
    end else begin
      pc          <= pc + 64'd4;
      IF_ID_pc    <= pc;
      IF_ID_instr <= Instruction;
      IF_ID_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Instruction_address;
  logic [31:0] Instruction;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_RegisterRd;
  logic [63:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
  logic        stall;
  logic        id_ex_bubble;
  logic        flush_id_ex;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  logic [31:0] imem [4];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] I_ADDI1 = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] I_ADD  = 32'h007302B3;  // add x5,x6,x7
  localparam logic [31:0] I_ADDI2 = 32'h00200113; // addi x2,x0,2
  localparam logic [31:0] I_ADDI3 = 32'h00300193; // addi x3,x0,3

  always #5 clk = ~clk;

  assign Instruction = imem[Instruction_address[3:2]];

  fetch_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .Instruction_address (Instruction_address),
    .Instruction         (Instruction),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .ID_EX_MemRead       (ID_EX_MemRead),
    .ID_EX_RegisterRd    (ID_EX_RegisterRd),
    .IF_ID_pc            (IF_ID_pc),
    .IF_ID_instr         (IF_ID_instr),
    .IF_ID_valid         (IF_ID_valid),
    .stall               (stall),
    .id_ex_bubble        (id_ex_bubble),
    .flush_id_ex         (flush_id_ex),
    .stall_count         (stall_count),
    .flush_count         (flush_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    imem[0] = I_ADDI1;
    imem[1] = I_ADD;
    imem[2] = I_ADDI2;
    imem[3] = I_ADDI3;
    reset = 1'b1;
    branch_taken = 1'b0;
    branch_target = 64'd0;
    ID_EX_MemRead = 1'b0;
    ID_EX_RegisterRd = 5'd0;
    step();
    step();

    check("rst_pc", Instruction_address, 64'd0);
    check("rst_ifid_pc", IF_ID_pc, 64'd0);
    check("rst_ifid_instr", {32'd0, IF_ID_instr}, {32'd0, NOP});
    check("rst_valid", {63'd0, IF_ID_valid}, 64'd0);
    check("rst_stall_cnt", {32'd0, stall_count}, 64'd0);
    check("rst_flush_cnt", {32'd0, flush_count}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);

    reset = 1'b0;
    step();
    check("adv1_pc", Instruction_address, 64'd4);
    check("adv1_ifid_pc", IF_ID_pc, 64'd0);
    check("adv1_instr", {32'd0, IF_ID_instr}, {32'd0, I_ADDI1});
    check("adv1_valid", {63'd0, IF_ID_valid}, 64'd1);
    step();
    check("adv2_pc", Instruction_address, 64'd8);
    check("adv2_ifid_pc", IF_ID_pc, 64'd4);
    check("adv2_instr", {32'd0, IF_ID_instr}, {32'd0, I_ADD});

    // load into x6 while add x5,x6,x7 sits in IF/ID
    ID_EX_MemRead = 1'b1;
    ID_EX_RegisterRd = 5'd6;
    #1;
    check("hz_stall", {63'd0, stall}, 64'd1);
    check("hz_bubble", {63'd0, id_ex_bubble}, 64'd1);
    check("hz_flush", {63'd0, flush_id_ex}, 64'd0);
    step();
    check("hold_pc", Instruction_address, 64'd8);
    check("hold_ifid_pc", IF_ID_pc, 64'd4);
    check("hold_instr", {32'd0, IF_ID_instr}, {32'd0, I_ADD});
    check("hold_valid", {63'd0, IF_ID_valid}, 64'd1);
    check("hold_stall_cnt", {32'd0, stall_count}, 64'd1);

    ID_EX_MemRead = 1'b0;
    #1;
    check("post_stall", {63'd0, stall}, 64'd0);

    // hazard on rs2 concurrent with a redirect
    ID_EX_MemRead = 1'b1;
    ID_EX_RegisterRd = 5'd7;
    branch_taken = 1'b1;
    branch_target = 64'h100;
    #1;
    check("br_stall", {63'd0, stall}, 64'd0);
    check("br_bubble", {63'd0, id_ex_bubble}, 64'd0);
    check("br_flush", {63'd0, flush_id_ex}, 64'd1);
    step();
    check("br_pc", Instruction_address, 64'h100);
    check("br_ifid_pc", IF_ID_pc, 64'd8);
    check("br_instr", {32'd0, IF_ID_instr}, {32'd0, NOP});
    check("br_valid", {63'd0, IF_ID_valid}, 64'd0);
    check("br_flush_cnt", {32'd0, flush_count}, 64'd1);
    check("br_stall_cnt", {32'd0, stall_count}, 64'd1);
    check("bubble_no_hz", {63'd0, stall}, 64'd0);

    branch_taken = 1'b0;
    ID_EX_MemRead = 1'b0;
    step();
    check("tgt_ifid_pc", IF_ID_pc, 64'h100);
    check("tgt_instr", {32'd0, IF_ID_instr}, {32'd0, I_ADDI1});

    // rd=0 matches rs1=x0 but must not stall
    ID_EX_MemRead = 1'b1;
    ID_EX_RegisterRd = 5'd0;
    #1;
    check("rd0_stall", {63'd0, stall}, 64'd0);
    step();
    check("rd0_pc", Instruction_address, 64'h108);

    ID_EX_MemRead = 1'b0;
    branch_taken = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    check("wrap_pre_pc", Instruction_address, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_flush_cnt", {32'd0, flush_count}, 64'd2);
    branch_taken = 1'b0;
    step();
    check("wrap_pc", Instruction_address, 64'd0);
    check("wrap_ifid_pc", IF_ID_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", {32'd0, IF_ID_instr}, {32'd0, I_ADDI3});

    // addi x3,x0,3 has rs2 field 3: load to x3 hazards, then reset wins over branch
    ID_EX_MemRead = 1'b1;
    ID_EX_RegisterRd = 5'd3;
    #1;
    check("rs2imm_stall", {63'd0, stall}, 64'd1);
    branch_taken = 1'b1;
    branch_target = 64'h200;
    reset = 1'b1;
    #1;
    check("rstbr_flush", {63'd0, flush_id_ex}, 64'd1);
    check("rstbr_stall", {63'd0, stall}, 64'd0);
    step();
    check("rstbr_pc", Instruction_address, 64'd0);
    check("rstbr_valid", {63'd0, IF_ID_valid}, 64'd0);
    check("rstbr_stall_cnt", {32'd0, stall_count}, 64'd0);
    check("rstbr_flush_cnt", {32'd0, flush_count}, 64'd0);
    check("rstbr_instr", {32'd0, IF_ID_instr}, {32'd0, NOP});

    reset = 1'b0;
    branch_taken = 1'b0;
    ID_EX_MemRead = 1'b0;
    step();
    check("rel_pc", Instruction_address, 64'd4);
    check("rel_ifid_pc", IF_ID_pc, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
